irq_timer_port: RTL
===================

// Module: irq_timer_port
// PURPOSE
//  Memory-mapped interrupt source for the cpu4510 bus: 16-bit down-counting timer, a write-triggered NMI
//  pulse generator and an 8-bit output port. It decodes the CPU bus in the same window as the other I/O,
//  feeds read data into the cpu_data_in mux, and drives the CPU irq/nmi inputs.
// PARAMETERS
//  BASE_ADDR   20'h0BFF8  8-byte register window base; BASE_ADDR[2:0] must be 0
//  NMI_WIDTH   4          nmi high time in clk cycles, 1..15
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  addr         in   20  registered CPU address (cpu address), read decode
//  addr_next    in   20  next-cycle CPU address (address_next), write decode
//  write_next   in   1   CPU write_next
//  data_next    in   8   CPU data_o_next
//  ready        in   1   bus ready; writes commit only when high
//  cs_o         out  1   addr is inside window; cpu_data_in mux selects data_o
//  data_o       out  8   read data, combinational from addr[2:0]; 8'h00 when cs_o=0
//  irq          out  1   level IRQ to CPU
//  nmi          out  1   NMI pulse to CPU
//  port_o       out  8   general output port
// BEHAVIOUR
//  - Write strobe: we = write_next & ready & (addr_next[19:3]==BASE_ADDR[19:3]); commits at posedge.
//  - Reset (async, reset_n=0): CTRL=0, STATUS=0, RELOAD=16'hFFFF, COUNT=16'hFFFF, PRESCALE=0, port_o=0,
//    nmi=0, nmi counter=0, irq=0. Release is synchronous to next posedge; no tick on the release edge.
//  - Register map (offset addr[2:0]):
//    0 CTRL  rw  [0]RUN [1]AUTO reload [2]TIE timer irq enable [3]SWI software irq; [7:4] read 0
//    1 STAT  r/w1c [0]TF timer underflow flag; [7:1] read 0
//    2 RLO   rw  reload[7:0]
//    3 RHI   rw  reload[15:8]; the write also loads COUNT <= {data_next, RLO} in the same cycle
//    4 CLO   r   COUNT[7:0]     5 CHI  r  COUNT[15:8]
//    6 NMIT  w   any write starts an NMI pulse; reads {3'b0, nmi, nmi counter[3:0]}
//    7 PORT  rw  port_o
//  - Tick: every clk cycle while RUN=1 (see CONFIGURATION for prescale).
//  - On tick: COUNT!=0 -> COUNT-1. COUNT==0 -> TF<=1; AUTO=1 -> COUNT<=RELOAD, else RUN<=0, COUNT stays 0.
//    Period with AUTO=1 is RELOAD+1 ticks; RELOAD=0 underflows on every tick.
//  - Simultaneous: an RHI write beats a tick in the same cycle (load wins, no decrement). A CTRL write
//    beats auto-clear of RUN. A TF set beats a W1C clear in the same cycle (flag stays 1).
//  - irq = registered (TF & TIE) | SWI; updates one cycle after the causing event. Clearing TF or TIE
//    drops irq on the next cycle.
//  - NMIT write: nmi<=1, counter<=NMI_WIDTH-1; counter decrements while nmi=1; nmi<=0 in the cycle after
//    counter reaches 0, so nmi is high exactly NMI_WIDTH cycles. An NMIT write while nmi=1 restarts the
//    count; nmi never drops, so the CPU sees no second edge.
//  - Reads have no side effects. COUNT halves are read independently; software reads CHI twice to detect tearing.
//  - A reset assertion mid-operation abandons the count and the nmi pulse immediately; irq and nmi go 0 asynchronously.
// CONFIGURATION
//  IRQ_TIMER_PRESCALE_EN defined: offset 6 reads/writes become PRESCALE (8 bit, reset 0); NMIT moves to an
//    offset 0 write with data_next[7]=1, bit not stored. The 8-bit prescale counter counts every clk; a tick
//    fires when it equals PRESCALE, then it clears. The prescale counter clears when RUN=0 or PRESCALE is
//    written. Tick rate = clk/(PRESCALE+1).
//  Not defined: tick every clk while RUN=1; no prescale logic; offset 6 is NMIT as mapped above.
// TESTING
//  1 Reset: reset_n=0 mid-count -> irq=0, nmi=0, port_o=0; CLO/CHI read FF/FF; CTRL reads 00.
//  2 RLO=03, RHI=00, CTRL=07 (RUN|AUTO|TIE) -> TF sets every 4 cycles; irq rises 1 cycle after the
//    first underflow; a STAT write of 01 clears it unless it collides with the next underflow.
//  3 One-shot: RLO=02, RHI=00, CTRL=05 -> after 3 ticks TF=1, RUN reads 0, COUNT holds 0000, no reload.
//  4 NMIT write (NMI_WIDTH=4) -> nmi high exactly 4 clks. A second write on cycle 3 -> single continuous
//    pulse of 7 clks.
//  5 Write gating: PORT write of A5 with ready=0 -> port_o unchanged; with ready=1 -> A5. An address
//    outside the window -> no change. cs_o=0 -> data_o=00.
//  6 IRQ_TIMER_PRESCALE_EN: PRESCALE=03, RLO=01, AUTO|RUN -> underflow every 8 clks.
//    CTRL=SWI -> irq=1 regardless of TIE.

Source files
------------

// File: rtl/irq_timer_port.sv
// irq_timer_port: bus-mapped 16-bit down-counting timer, write-triggered NMI pulse
// generator and an 8-bit output port for the cpu4510 bus.
// Optional feature macro: IRQ_TIMER_PRESCALE_EN
//   When defined, offset 6 becomes an 8-bit PRESCALE register. NMI is then started by
//   writing offset 0 with data bit 7 set.
module irq_timer_port #(
   parameter logic [19:0] BASE_ADDR = 20'h0BFF8,
   parameter int unsigned NMI_WIDTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [19:0] addr,
   input  logic [19:0] addr_next,
   input  logic        write_next,
   input  logic [7:0]  data_next,
   input  logic        ready,
   output logic        cs_o,
   output logic [7:0]  data_o,
   output logic        irq,
   output logic        nmi,
   output logic [7:0]  port_o
);

   localparam logic [3:0] NMI_LAST = 4'(NMI_WIDTH - 1);

   // ctrl bits: [0] RUN, [1] AUTO, [2] TIE, [3] SWI
   logic [3:0]  ctrl_q, ctrl_d;
   logic        tf_q, tf_d;
   logic [15:0] reload_q, reload_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  port_q, port_d;
   logic        nmi_q, nmi_d;
   logic [3:0]  nmi_cnt_q, nmi_cnt_d;
   logic        irq_q, irq_d;

   logic        we, wr_ctrl, wr_stat, wr_rlo, wr_rhi, wr_off6, wr_port, nmi_go;
   logic        tick, uf;

`ifdef IRQ_TIMER_PRESCALE_EN
   logic [7:0]  prescale_q, prescale_d;
   logic [7:0]  pcnt_q, pcnt_d;
`endif

   // write decode: one strobe per register, only when the bus is ready
   always_comb begin
      we      = write_next & ready & (addr_next[19:3] == BASE_ADDR[19:3]);
      wr_ctrl = we & (addr_next[2:0] == 3'd0);
      wr_stat = we & (addr_next[2:0] == 3'd1);
      wr_rlo  = we & (addr_next[2:0] == 3'd2);
      wr_rhi  = we & (addr_next[2:0] == 3'd3);
      wr_off6 = we & (addr_next[2:0] == 3'd6);
      wr_port = we & (addr_next[2:0] == 3'd7);
`ifdef IRQ_TIMER_PRESCALE_EN
      nmi_go  = wr_ctrl & data_next[7];
`else
      nmi_go  = wr_off6;
`endif
   end

`ifdef IRQ_TIMER_PRESCALE_EN
   // prescaler: tick when the free counter matches PRESCALE; cleared while stopped or on rewrite
   always_comb begin
      prescale_d = prescale_q;
      pcnt_d     = pcnt_q + 8'd1;
      tick       = ctrl_q[0] & (pcnt_q == prescale_q);
      if (wr_off6) prescale_d = data_next;
      if (!ctrl_q[0] || wr_off6 || (pcnt_q == prescale_q)) pcnt_d = 8'd0;
   end
`else
   // no prescaler: one tick per clock while running
   always_comb begin
      tick = ctrl_q[0];
   end
`endif

   // timer, flag, port and nmi next-state; register writes take priority over tick side effects
   always_comb begin
      ctrl_d    = ctrl_q;
      tf_d      = tf_q;
      reload_d  = reload_q;
      count_d   = count_q;
      port_d    = port_q;
      nmi_d     = nmi_q;
      nmi_cnt_d = nmi_cnt_q;
      uf        = 1'b0;
      if (tick) begin
         if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
         end else begin
            uf = 1'b1;
            if (ctrl_q[1]) count_d = reload_q;
            else           ctrl_d[0] = 1'b0;
         end
      end
      if (wr_ctrl) ctrl_d = data_next[3:0];
      // a set from underflow outranks a same-cycle W1C
      if (wr_stat && data_next[0]) tf_d = 1'b0;
      if (uf) tf_d = 1'b1;
      if (wr_rlo) reload_d[7:0] = data_next;
      if (wr_rhi) begin
         reload_d[15:8] = data_next;
         count_d        = {data_next, reload_q[7:0]};
      end
      if (wr_port) port_d = data_next;
      // restart while high keeps nmi asserted, so the CPU sees a single edge
      if (nmi_go) begin
         nmi_d     = 1'b1;
         nmi_cnt_d = NMI_LAST;
      end else if (nmi_q) begin
         if (nmi_cnt_q == 4'd0) nmi_d = 1'b0;
         else                   nmi_cnt_d = nmi_cnt_q - 4'd1;
      end
      irq_d = (tf_q & ctrl_q[2]) | ctrl_q[3];
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q    <= 4'd0;
         tf_q      <= 1'b0;
         reload_q  <= 16'hFFFF;
         count_q   <= 16'hFFFF;
         port_q    <= 8'd0;
         nmi_q     <= 1'b0;
         nmi_cnt_q <= 4'd0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         tf_q      <= tf_d;
         reload_q  <= reload_d;
         count_q   <= count_d;
         port_q    <= port_d;
         nmi_q     <= nmi_d;
         nmi_cnt_q <= nmi_cnt_d;
         irq_q     <= irq_d;
      end
   end

`ifdef IRQ_TIMER_PRESCALE_EN
   // prescaler registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescale_q <= 8'd0;
         pcnt_q     <= 8'd0;
      end else begin
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
      end
   end
`endif

   // read mux: side-effect free, zero outside the window
   always_comb begin
      cs_o   = (addr[19:3] == BASE_ADDR[19:3]);
      data_o = 8'h00;
      if (cs_o) begin
         unique case (addr[2:0])
            3'd0: data_o = {4'b0, ctrl_q};
            3'd1: data_o = {7'b0, tf_q};
            3'd2: data_o = reload_q[7:0];
            3'd3: data_o = reload_q[15:8];
            3'd4: data_o = count_q[7:0];
            3'd5: data_o = count_q[15:8];
`ifdef IRQ_TIMER_PRESCALE_EN
            3'd6: data_o = prescale_q;
`else
            3'd6: data_o = {3'b0, nmi_q, nmi_cnt_q};
`endif
            3'd7: data_o = port_q;
            default: data_o = 8'h00;
         endcase
      end
   end

   assign irq    = irq_q;
   assign nmi    = nmi_q;
   assign port_o = port_q;

endmodule
